// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard handshake bundle between the pipeline datapath and the stall/flush sequencer.
// master = sequencer (drives load/flush enables), slave = pipeline (drives hazard status).
interface pipeline_hazard_ctrl_if;
    logic imem_busy;
    logic imem_resp;
    logic dmem_busy;
    logic load_use;
    logic br_mispredict;
    logic load_pc;
    logic load_if_id;
    logic load_id_ex;
    logic load_ex_mem;
    logic load_mem_wb;
    logic flush_if_id;
    logic flush_id_ex;

    modport master (
        input  imem_busy, imem_resp, dmem_busy, load_use, br_mispredict,
        output load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
               flush_if_id, flush_id_ex
    );

    modport slave (
        output imem_busy, imem_resp, dmem_busy, load_use, br_mispredict,
        input  load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
               flush_if_id, flush_id_ex
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage rv32i pipeline, with dmem watchdog.
// Optional performance counters are built only when PIPE_PERF_CNT_EN is defined.
//
//   state | meaning
//   RUN   | normal issue; freezes, redirects and bubbles resolved each cycle
//   DRAIN | wrong-path fetch still outstanding; its response is dropped
module pipeline_hazard_ctrl #(
    parameter int WD_LIMIT = 1024,
    parameter int WD_W     = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.master hz,
    output logic                  wd_timeout,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           flush_events
);

    typedef enum logic {RUN, DRAIN} state_t;

    localparam logic [WD_W-1:0] WD_MAX = WD_W'(WD_LIMIT);

    state_t          state;
    logic [WD_W-1:0] wd_cnt;
    logic            front_stall;
    logic            redirect;

    assign front_stall = hz.imem_busy & ~hz.imem_resp;
    assign redirect    = ~rst & ~hz.dmem_busy & hz.br_mispredict & (state == RUN);

    always_comb begin
        hz.load_pc     = 1'b0;
        hz.load_if_id  = 1'b0;
        hz.load_id_ex  = 1'b0;
        hz.load_ex_mem = 1'b0;
        hz.load_mem_wb = 1'b0;
        hz.flush_if_id = 1'b0;
        hz.flush_id_ex = 1'b0;
        if (!rst && !hz.dmem_busy) begin
            hz.load_ex_mem = 1'b1;
            hz.load_mem_wb = 1'b1;
            if (state == DRAIN) begin
                hz.flush_if_id = 1'b1;
                hz.flush_id_ex = 1'b1;
            end else if (hz.br_mispredict) begin
                hz.load_pc     = 1'b1;
                hz.flush_if_id = 1'b1;
                hz.flush_id_ex = 1'b1;
            end else if (front_stall || hz.load_use) begin
                hz.flush_id_ex = 1'b1;
            end else begin
                hz.load_pc    = 1'b1;
                hz.load_if_id = 1'b1;
                hz.load_id_ex = 1'b1;
            end
        end
    end

    // The stale response is dropped whenever it lands, even under a dmem freeze.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:     if (redirect && front_stall) state <= DRAIN;
                DRAIN:   if (hz.imem_resp) state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt     <= '0;
            wd_timeout <= 1'b0;
        end else if (hz.dmem_busy) begin
            if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + 1'b1;
            if (wd_cnt >= WD_MAX - 1'b1) wd_timeout <= 1'b1;
        end else begin
            wd_cnt <= '0;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (!hz.load_pc) stall_cycles <= stall_cycles + 32'd1;
            if (redirect)    flush_events <= flush_events + 32'd1;
        end
    end
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif

endmodule
